pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Consumer end of the main Control decoder: registers the decoded control bundle through ID/EX, EX/MEM
//  and MEM/WB, drives stage-local control to the datapath, detects load-use hazards (stall + bubble),
//  flushes IF/ID on taken branch/jump, and (optionally) produces EX-stage forwarding selects.
// PARAMETERS
//  REG_AW  5  register-specifier width
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       synchronous, active-high reset
//  RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i, MemRead_i  in 1 each  ID-stage control from decoder
//  ALUOp_i        in   2       ID-stage ALUOp (0 R-type, 1 add, 2 sub)
//  Rs_i, Rt_i, Rd_i  in REG_AW ID-stage register specifiers
//  BrTaken_i      in   1       ID-stage branch resolved taken (Branch & equal)
//  Jump_i         in   1       ID-stage jump
//  PCWrite_o      out  1       0 = hold PC
//  IFIDWrite_o    out  1       0 = hold IF/ID register
//  IFFlush_o      out  1       1 = zero IF/ID instruction next edge
//  EX_ALUSrc_o    out  1       EX-stage ALU B select
//  EX_ALUOp_o     out  2       EX-stage ALUOp
//  EX_WrReg_o     out  REG_AW  EX destination (RegDst ? Rd : Rt)
//  MEM_MemRead_o, MEM_MemWrite_o  out 1  data-memory strobes
//  WB_RegWrite_o, WB_MemtoReg_o   out 1  register-file write enable / source
//  WB_WrReg_o     out  REG_AW  register-file write address
//  ForwardA_o, ForwardB_o  out 2  EX operand select: 0 regfile, 1 MEM/WB, 2 EX/MEM
// BEHAVIOUR
//  - Reset: all stage registers cleared (bubble); every registered output 0; PCWrite_o=IFIDWrite_o=1,
//    IFFlush_o=0, Forward*_o=0. Reset mid-operation discards all in-flight control next edge.
//  - Latency: ID control appears on EX_* 1 cycle later, MEM_* 2, WB_* 3. Rs/Rt carried into ID/EX.
//  - Load-use: hazard = ID/EX.MemRead & ID/EX.WrReg!=0 & (WrReg==Rs_i | WrReg==Rt_i). On hazard
//    (combinational): PCWrite_o=0, IFIDWrite_o=0, ID/EX loads bubble (all control 0, WrReg 0).
//    Exactly one bubble per load-use; the held instruction re-decodes next cycle with no hazard.
//  - Flush: IFFlush_o = BrTaken_i | Jump_i, unless hazard is asserted (stall wins; branch re-evaluated
//    after stall). Branching instruction itself proceeds into ID/EX normally.
//  - Register $0: any WrReg==0 forces RegWrite to 0 entering EX/MEM; never forwarded, never hazards.
//  - EX/MEM and MEM/WB always advance (no back-pressure from memory).
//  - Forwarding (EX/MEM priority over MEM/WB): EX/MEM.RegWrite & WrReg!=0 & WrReg==ID/EX.Rs -> A=2;
//    else MEM/WB likewise -> A=1; else 0. Same for Rt -> B.
// CONFIGURATION
//  PIPE_CTRL_FWD_EN defined: forwarding as above; hazard unit only handles load-use.
//  Not defined: ForwardA_o=ForwardB_o=0 constant; hazard widened to any RAW: ID Rs/Rt matching a
//  nonzero WrReg with RegWrite in ID/EX or EX/MEM stalls (PC/IFID hold, bubble) until it reaches MEM/WB;
//  register file assumed write-before-read within a cycle.
// STRUCTURE
//  Shared package: ALUOp encodings (ALUOP_RTYPE=0, ALUOP_ADD=1, ALUOP_SUB=2), FWD_* select constants,
//  packed stage-control struct typedefs (ex/mem/wb fields).
//  One sub-module: pipe_hazard_detect (combinational stall/flush/forward logic); stage registers in top.
// TESTING
//  1 lw $2,0($1); add $3,$2,$4 -> one cycle PCWrite_o=IFIDWrite_o=0, EX_* bubble, then add proceeds;
//    with FWD_EN add sees ForwardA_o=1 (MEM/WB).
//  2 add $2,$1,$1; sub $3,$2,$2 (FWD_EN) -> sub in EX: ForwardA_o=ForwardB_o=2; no stall.
//    Without FWD_EN -> 2 stall cycles, Forward*=0.
//  3 beq taken in ID -> IFFlush_o=1 that cycle, next IF/ID instruction produces all-zero EX control.
//  4 beq taken same cycle as load-use hazard -> IFFlush_o=0, stall; next cycle IFFlush_o=1.
//  5 add $0,$1,$1; add $3,$0,$0 -> WB_RegWrite_o=0, Forward*=0, no stall.
//  6 rst_i asserted with 3 instructions in flight -> next edge all stage outputs 0, PCWrite_o=1.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: ALUOp codes, forwarding selects and
// the per-stage control bundles carried through ID/EX, EX/MEM and MEM/WB.
package pipe_ctrl_unit_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'd0;
    localparam logic [1:0] ALUOP_ADD   = 2'd1;
    localparam logic [1:0] ALUOP_SUB   = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // EX/MEM result is younger than MEM/WB, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic hit_exmem, input logic hit_memwb);
        if (hit_exmem)      return FWD_EXMEM;
        else if (hit_memwb) return FWD_MEMWB;
        else                return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_hazard.sv
// Combinational hazard unit: stall/flush decisions and EX operand forwarding selects.
// PIPE_CTRL_FWD_EN selects forwarding + load-use stalls; otherwise any RAW stalls until WB.
module pipe_hazard_detect
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              idex_mem_read_i,
    input  logic              idex_reg_write_i,
    input  logic [REG_AW-1:0] idex_wr_reg_i,
    input  logic [REG_AW-1:0] idex_rs_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_wr_reg_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_wr_reg_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              br_taken_i,
    input  logic              jump_i,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              if_flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    logic ex_match;

    assign ex_match = (idex_wr_reg_i != '0) &&
                      ((idex_wr_reg_i == id_rs_i) || (idex_wr_reg_i == id_rt_i));

`ifdef PIPE_CTRL_FWD_EN
    logic exmem_wr_ok;
    logic memwb_wr_ok;
    logic unused_fwd;

    assign stall_o     = idex_mem_read_i & ex_match;
    assign exmem_wr_ok = exmem_reg_write_i && (exmem_wr_reg_i != '0);
    assign memwb_wr_ok = memwb_reg_write_i && (memwb_wr_reg_i != '0);
    assign fwd_a_o     = fwd_sel(exmem_wr_ok && (exmem_wr_reg_i == idex_rs_i),
                                 memwb_wr_ok && (memwb_wr_reg_i == idex_rs_i));
    assign fwd_b_o     = fwd_sel(exmem_wr_ok && (exmem_wr_reg_i == idex_rt_i),
                                 memwb_wr_ok && (memwb_wr_reg_i == idex_rt_i));
    assign unused_fwd  = idex_reg_write_i;
`else
    logic mem_match;
    logic unused_nofwd;

    // Without forwarding a producer must reach MEM/WB (write-before-read regfile) first.
    assign mem_match    = (exmem_wr_reg_i != '0) &&
                          ((exmem_wr_reg_i == id_rs_i) || (exmem_wr_reg_i == id_rt_i));
    assign stall_o      = (idex_reg_write_i & ex_match) | (exmem_reg_write_i & mem_match);
    assign fwd_a_o      = FWD_RF;
    assign fwd_b_o      = FWD_RF;
    assign unused_nofwd = ^{idex_mem_read_i, idex_rs_i, idex_rt_i,
                            memwb_reg_write_i, memwb_wr_reg_i};
`endif

    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;
    assign if_flush_o   = (br_taken_i | jump_i) & ~stall_o;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID/EX, EX/MEM, MEM/WB control registers plus hazard/flush/forward.
// Optional forwarding enabled by defining PIPE_CTRL_FWD_EN.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [REG_AW-1:0] Rs_i,
    input  logic [REG_AW-1:0] Rt_i,
    input  logic [REG_AW-1:0] Rd_i,
    input  logic              BrTaken_i,
    input  logic              Jump_i,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic              IFFlush_o,
    output logic              EX_ALUSrc_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic [REG_AW-1:0] EX_WrReg_o,
    output logic              MEM_MemRead_o,
    output logic              MEM_MemWrite_o,
    output logic              WB_RegWrite_o,
    output logic              WB_MemtoReg_o,
    output logic [REG_AW-1:0] WB_WrReg_o,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o
);

    ex_ctrl_t          idex_ex_q,    idex_ex_d;
    mem_ctrl_t         idex_mem_q,   idex_mem_d;
    wb_ctrl_t          idex_wb_q,    idex_wb_d;
    logic [REG_AW-1:0] idex_rs_q,    idex_rs_d;
    logic [REG_AW-1:0] idex_rt_q,    idex_rt_d;
    logic [REG_AW-1:0] idex_wr_q,    idex_wr_d;
    mem_ctrl_t         exmem_mem_q,  exmem_mem_d;
    wb_ctrl_t          exmem_wb_q,   exmem_wb_d;
    logic [REG_AW-1:0] exmem_wr_q,   exmem_wr_d;
    wb_ctrl_t          memwb_wb_q,   memwb_wb_d;
    logic [REG_AW-1:0] memwb_wr_q,   memwb_wr_d;
    logic              stall;

    pipe_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .idex_mem_read_i   (idex_mem_q.mem_read),
        .idex_reg_write_i  (idex_wb_q.reg_write),
        .idex_wr_reg_i     (idex_wr_q),
        .idex_rs_i         (idex_rs_q),
        .idex_rt_i         (idex_rt_q),
        .exmem_reg_write_i (exmem_wb_q.reg_write),
        .exmem_wr_reg_i    (exmem_wr_q),
        .memwb_reg_write_i (memwb_wb_q.reg_write),
        .memwb_wr_reg_i    (memwb_wr_q),
        .id_rs_i           (Rs_i),
        .id_rt_i           (Rt_i),
        .br_taken_i        (BrTaken_i),
        .jump_i            (Jump_i),
        .stall_o           (stall),
        .pc_write_o        (PCWrite_o),
        .ifid_write_o      (IFIDWrite_o),
        .if_flush_o        (IFFlush_o),
        .fwd_a_o           (ForwardA_o),
        .fwd_b_o           (ForwardB_o)
    );

    always_comb begin
        idex_ex_d  = '{alu_src: ALUSrc_i, alu_op: ALUOp_i};
        idex_mem_d = '{mem_read: MemRead_i, mem_write: MemWrite_i};
        idex_wb_d  = '{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i};
        idex_rs_d  = Rs_i;
        idex_rt_d  = Rt_i;
        idex_wr_d  = RegDst_i ? Rd_i : Rt_i;
        // A stalled instruction stays in IF/ID; EX receives a bubble instead.
        if (stall) begin
            idex_ex_d  = '0;
            idex_mem_d = '0;
            idex_wb_d  = '0;
            idex_rs_d  = '0;
            idex_rt_d  = '0;
            idex_wr_d  = '0;
        end
        exmem_mem_d = idex_mem_q;
        exmem_wb_d  = idex_wb_q;
        exmem_wb_d.reg_write = idex_wb_q.reg_write && (idex_wr_q != '0);
        exmem_wr_d  = idex_wr_q;
        memwb_wb_d  = exmem_wb_q;
        memwb_wr_d  = exmem_wr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= '0;
            idex_wb_q   <= '0;
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_wr_q   <= '0;
            exmem_mem_q <= '0;
            exmem_wb_q  <= '0;
            exmem_wr_q  <= '0;
            memwb_wb_q  <= '0;
            memwb_wr_q  <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
            idex_wr_q   <= idex_wr_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_wr_q  <= exmem_wr_d;
            memwb_wb_q  <= memwb_wb_d;
            memwb_wr_q  <= memwb_wr_d;
        end
    end

    assign EX_ALUSrc_o    = idex_ex_q.alu_src;
    assign EX_ALUOp_o     = idex_ex_q.alu_op;
    assign EX_WrReg_o     = idex_wr_q;
    assign MEM_MemRead_o  = exmem_mem_q.mem_read;
    assign MEM_MemWrite_o = exmem_mem_q.mem_write;
    assign WB_RegWrite_o  = memwb_wb_q.reg_write;
    assign WB_MemtoReg_o  = memwb_wb_q.mem_to_reg;
    assign WB_WrReg_o     = memwb_wr_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: an instruction-level pipeline model predicts each
// cycle's outputs, a monitor on the falling edge compares them against the DUT.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, BrTaken, Jump;
    logic [1:0] ALUOp;
    logic [4:0] Rs, Rt, Rd;
    logic       PCWrite, IFIDWrite, IFFlush, EX_ALUSrc, MEM_MemRead, MEM_MemWrite;
    logic       WB_RegWrite, WB_MemtoReg;
    logic [1:0] EX_ALUOp, ForwardA, ForwardB;
    logic [4:0] EX_WrReg, WB_WrReg;

    pipe_ctrl_unit #(.REG_AW(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .RegDst_i(RegDst), .ALUSrc_i(ALUSrc), .MemtoReg_i(MemtoReg), .RegWrite_i(RegWrite),
        .MemWrite_i(MemWrite), .MemRead_i(MemRead), .ALUOp_i(ALUOp),
        .Rs_i(Rs), .Rt_i(Rt), .Rd_i(Rd), .BrTaken_i(BrTaken), .Jump_i(Jump),
        .PCWrite_o(PCWrite), .IFIDWrite_o(IFIDWrite), .IFFlush_o(IFFlush),
        .EX_ALUSrc_o(EX_ALUSrc), .EX_ALUOp_o(EX_ALUOp), .EX_WrReg_o(EX_WrReg),
        .MEM_MemRead_o(MEM_MemRead), .MEM_MemWrite_o(MEM_MemWrite),
        .WB_RegWrite_o(WB_RegWrite), .WB_MemtoReg_o(WB_MemtoReg), .WB_WrReg_o(WB_WrReg),
        .ForwardA_o(ForwardA), .ForwardB_o(ForwardB)
    );

    typedef struct packed {
        logic regdst, alusrc, memtoreg, regwrite, memwrite, memread;
        logic [1:0] aluop;
        logic [4:0] rs, rt, rd;
        logic br, jmp;
    } ins_t;

    // One in-flight instruction as the later stages see it.
    typedef struct packed {
        logic alusrc;
        logic [1:0] aluop;
        logic mr, mw, rw, m2r;
        logic [4:0] rs, rt, wr;
    } rec_t;

    typedef struct packed {
        logic pcw, ifidw, flush;
        logic alusrc;
        logic [1:0] aluop;
        logic [4:0] exwr;
        logic mr, mw;
        logic rw, m2r;
        logic [4:0] wbwr;
        logic [1:0] fa, fb;
    } exp_t;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;

    rec_t m_ex, m_mem, m_wb;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic bit writes(input rec_t r);
        return r.rw && (r.wr != 5'd0);
    endfunction

    function automatic bit dep(input rec_t r, input logic [4:0] rs, input logic [4:0] rt);
        return (r.wr != 5'd0) && ((r.wr == rs) || (r.wr == rt));
    endfunction

    function automatic bit model_hazard(input ins_t x);
`ifdef PIPE_CTRL_FWD_EN
        return m_ex.mr && dep(m_ex, x.rs, x.rt);
`else
        return (writes(m_ex) && dep(m_ex, x.rs, x.rt)) ||
               (writes(m_mem) && dep(m_mem, x.rs, x.rt));
`endif
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef PIPE_CTRL_FWD_EN
        if (writes(m_mem) && m_mem.wr == src) return 2'd2;
        if (writes(m_wb) && m_wb.wr == src)   return 2'd1;
`endif
        return 2'd0;
    endfunction

    function automatic ins_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic br);
        ins_t x;
        x = '0;
        x.rs = rs; x.rt = rt; x.rd = rd;
        case (kind)
            K_R:   begin x.regdst = 1; x.regwrite = 1; x.aluop = 2'd0; end
            K_LW:  begin x.alusrc = 1; x.memtoreg = 1; x.regwrite = 1; x.memread = 1; x.aluop = 2'd1; end
            K_SW:  begin x.alusrc = 1; x.memwrite = 1; x.aluop = 2'd1; end
            K_BEQ: begin x.aluop = 2'd2; x.br = br; end
            default: begin x.jmp = 1; end
        endcase
        return x;
    endfunction

    // Present one ID-stage instruction for a cycle, record the prediction, advance the model.
    task automatic drive_cycle(input ins_t x, input bit r, output bit haz);
        exp_t e;
        rec_t n;
        rst = r;
        RegDst = x.regdst; ALUSrc = x.alusrc; MemtoReg = x.memtoreg; RegWrite = x.regwrite;
        MemWrite = x.memwrite; MemRead = x.memread; ALUOp = x.aluop;
        Rs = x.rs; Rt = x.rt; Rd = x.rd; BrTaken = x.br; Jump = x.jmp;
        haz = model_hazard(x);
        e.pcw = !haz; e.ifidw = !haz; e.flush = (x.br || x.jmp) && !haz;
        e.alusrc = m_ex.alusrc; e.aluop = m_ex.aluop; e.exwr = m_ex.wr;
        e.mr = m_mem.mr; e.mw = m_mem.mw;
        e.rw = m_wb.rw; e.m2r = m_wb.m2r; e.wbwr = m_wb.wr;
        e.fa = model_fwd(m_ex.rs); e.fb = model_fwd(m_ex.rt);
        sb.push_back(e);
        @(posedge clk); #1;
        if (r) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb = m_mem;
            m_mem = m_ex;
            m_mem.rw = writes(m_ex);
            n = '0;
            if (!haz) begin
                n.alusrc = x.alusrc; n.aluop = x.aluop; n.mr = x.memread; n.mw = x.memwrite;
                n.rw = x.regwrite; n.m2r = x.memtoreg; n.rs = x.rs; n.rt = x.rt;
                n.wr = x.regdst ? x.rd : x.rt;
            end
            m_ex = n;
        end
    endtask

    // Issue an instruction until it leaves ID; a taken branch/jump kills the next fetch.
    task automatic run_ins(input ins_t x);
        bit h;
        int n;
        n = 0;
        do begin
            drive_cycle(x, 1'b0, h);
            n++;
        end while (h && n < 8);
        checks++;
        if (h) begin
            errors++;
            $display("FAIL stall_bound: still stalled after %0d cycles, required release within 8", n);
        end
        if (x.br || x.jmp) drive_cycle('0, 1'b0, h);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) run_ins('0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctl", {13'd0, PCWrite, IFIDWrite, IFFlush}, {13'd0, e.pcw, e.ifidw, e.flush});
                chk("ex", {8'd0, EX_ALUSrc, EX_ALUOp, EX_WrReg}, {8'd0, e.alusrc, e.aluop, e.exwr});
                chk("mem", {14'd0, MEM_MemRead, MEM_MemWrite}, {14'd0, e.mr, e.mw});
                chk("wb", {9'd0, WB_RegWrite, WB_MemtoReg, WB_WrReg}, {9'd0, e.rw, e.m2r, e.wbwr});
                chk("fwd", {12'd0, ForwardA, ForwardB}, {12'd0, e.fa, e.fb});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit   h;
        int   kind;
        ins_t x;
        rst = 1'b1;
        RegDst = 0; ALUSrc = 0; MemtoReg = 0; RegWrite = 0; MemWrite = 0; MemRead = 0;
        ALUOp = 0; Rs = 0; Rt = 0; Rd = 0; BrTaken = 0; Jump = 0;
        @(posedge clk); #1;
        m_ex = '0; m_mem = '0; m_wb = '0;
        drive_cycle('0, 1'b1, h);
        drain();

        // load-use
        run_ins(mk(K_LW, 5'd1, 5'd2, 5'd0, 0));
        run_ins(mk(K_R, 5'd2, 5'd4, 5'd3, 0));
        drain();
        // back-to-back ALU dependency
        run_ins(mk(K_R, 5'd1, 5'd1, 5'd2, 0));
        run_ins(mk(K_R, 5'd2, 5'd2, 5'd3, 0));
        drain();
        // taken branch flush
        run_ins(mk(K_BEQ, 5'd5, 5'd6, 5'd0, 1));
        run_ins(mk(K_R, 5'd1, 5'd1, 5'd7, 0));
        drain();
        // taken branch colliding with load-use
        run_ins(mk(K_LW, 5'd1, 5'd2, 5'd0, 0));
        run_ins(mk(K_BEQ, 5'd2, 5'd5, 5'd0, 1));
        drain();
        // writes to $0
        run_ins(mk(K_R, 5'd1, 5'd1, 5'd0, 0));
        run_ins(mk(K_R, 5'd0, 5'd0, 5'd3, 0));
        drain();
        // reset with instructions in flight
        run_ins(mk(K_LW, 5'd1, 5'd2, 5'd0, 0));
        run_ins(mk(K_SW, 5'd3, 5'd4, 5'd0, 0));
        run_ins(mk(K_R, 5'd5, 5'd6, 5'd7, 0));
        drive_cycle(mk(K_R, 5'd1, 5'd1, 5'd1, 0), 1'b1, h);
        drain();

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 4);
            x = mk(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) drive_cycle(x, 1'b1, h);
            else run_ins(x);
        end
        drain();

        @(negedge clk);
        @(posedge clk); #1;
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
